gpio_input_debounce: RTL

//   Input-side counterpart to the LED output path: reads WIDTH board buttons
//   or switches through GENERIC_IOB input buffers (INPUT_USED=1).

---
 rtl/gpio_input_debounce.sv | 82 ++++++++
 1 files changed

// File: rtl/gpio_input_debounce.sv
// Per-channel two-flop synchroniser and debounce filter for board buttons/switches.
// Emits a clean level, one-cycle press/release pulses and a wrapping press-event count.
module gpio_input_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] state_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [7:0]       press_count
);

    localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] pol;
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [7:0]       press_q, press_d;

    assign pol = ACTIVE_LOW ? ~pins_in : pins_in;

    // Counter value 0 is STABLE, non-zero is SETTLING; terminal count with a mismatch accepts.
    always_comb begin
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != state_q[i]) begin
                if (cnt_q[i] == TERM) begin
                    state_d[i] = s2_q[i];
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // One increment per cycle with any press, regardless of how many channels pressed.
    assign press_d = press_q + {7'd0, |rise_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            press_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= pol;
            s2_q    <= s1_q;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign state_out   = state_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign press_count = press_q;

endmodule
